// File: rtl/prf_read_arbiter_pkg.sv
// prf_read_arbiter_pkg: shared PRF sizing constants and the per-port read request type
package prf_read_arbiter_pkg;
  localparam int PR_COUNT = 128;
  localparam int LOG_PR_COUNT = $clog2(PR_COUNT);
  localparam int PRF_BANK_COUNT = 4;
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int PRF_RR_COUNT = 14;
  localparam int LOG_PRF_RR_COUNT = $clog2(PRF_RR_COUNT);
  localparam int PRF_READ_PORT_COUNT = 2;
  localparam int PRF_ROW_WIDTH = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  typedef struct packed {
    logic valid;
    logic [PRF_ROW_WIDTH-1:0] index;
    logic [LOG_PRF_RR_COUNT-1:0] rr;
  } prf_read_port_t;
endpackage

// File: rtl/prf_read_arbiter_bank_rr_select.sv
// prf_bank_rr_select: round-robin pick of up to PRF_READ_PORT_COUNT requestors for one bank
module prf_bank_rr_select
  import prf_read_arbiter_pkg::*;
(
  input  logic [PRF_RR_COUNT-1:0]                                  req,
  input  logic [LOG_PRF_RR_COUNT-1:0]                              ptr,
  output logic [PRF_READ_PORT_COUNT-1:0][PRF_RR_COUNT-1:0]         grant,
  output logic [PRF_READ_PORT_COUNT-1:0]                           grant_valid,
  output logic [PRF_READ_PORT_COUNT-1:0][LOG_PRF_RR_COUNT-1:0]     grant_rr,
  output logic [LOG_PRF_RR_COUNT-1:0]                              next_ptr
);
  always_comb begin
    logic [LOG_PRF_RR_COUNT:0] sum;
    logic [LOG_PRF_RR_COUNT-1:0] idx;
    logic taken;
    grant = '0;
    grant_valid = '0;
    grant_rr = '0;
    next_ptr = ptr;
    sum = '0;
    idx = '0;
    taken = 1'b0;
    for (int k = 0; k < PRF_RR_COUNT; k++) begin
      sum = {1'b0, ptr} + (LOG_PRF_RR_COUNT+1)'(k);
      idx = sum >= (LOG_PRF_RR_COUNT+1)'(PRF_RR_COUNT) ? LOG_PRF_RR_COUNT'(sum - (LOG_PRF_RR_COUNT+1)'(PRF_RR_COUNT)) : LOG_PRF_RR_COUNT'(sum);
      taken = 1'b0;
      for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
        if (req[idx] && !taken && !grant_valid[p]) begin
          grant[p][idx] = 1'b1;
          grant_valid[p] = 1'b1;
          grant_rr[p] = idx;
          next_ptr = idx == LOG_PRF_RR_COUNT'(PRF_RR_COUNT-1) ? '0 : idx + 1'b1;
          taken = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/prf_read_arbiter.sv
// prf_read_arbiter: steers PRF read requests to banks, grants ports round-robin, registers port addresses
module prf_read_arbiter
  import prf_read_arbiter_pkg::*;
(
  input  logic                                                                  CLK,
  input  logic                                                                  RST,
  input  logic [PRF_RR_COUNT-1:0]                                               read_req_valid_by_rr,
  input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]                             read_req_pr_by_rr,
  output logic [PRF_RR_COUNT-1:0]                                               read_req_ready_by_rr,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]                    read_port_valid_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][PRF_ROW_WIDTH-1:0] read_port_index_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][LOG_PRF_RR_COUNT-1:0] read_port_rr_by_bank_by_port
);
  logic [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] req_by_bank;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][PRF_RR_COUNT-1:0] grant;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0] grant_valid;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][LOG_PRF_RR_COUNT-1:0] grant_rr;
  logic [PRF_BANK_COUNT-1:0][LOG_PRF_RR_COUNT-1:0] ptr, next_ptr;
  prf_read_port_t [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0] port_d, port_q;
  always_comb begin
    req_by_bank = '0;
    for (int i = 0; i < PRF_RR_COUNT; i++)
      req_by_bank[read_req_pr_by_rr[i][LOG_PRF_BANK_COUNT-1:0]][i] = read_req_valid_by_rr[i];
  end
  for (genvar g = 0; g < PRF_BANK_COUNT; g++) begin : g_bank
    prf_bank_rr_select u_sel (
      .req         (req_by_bank[g]),
      .ptr         (ptr[g]),
      .grant       (grant[g]),
      .grant_valid (grant_valid[g]),
      .grant_rr    (grant_rr[g]),
      .next_ptr    (next_ptr[g])
    );
  end
  always_comb begin
    read_req_ready_by_rr = '0;
    port_d = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++)
      for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
        read_req_ready_by_rr = read_req_ready_by_rr | grant[b][p];
        port_d[b][p].valid = grant_valid[b][p];
        port_d[b][p].index = grant_valid[b][p] ? read_req_pr_by_rr[grant_rr[b][p]][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT] : '0;
        port_d[b][p].rr = grant_rr[b][p];
      end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
      port_q <= '0;
    end else begin
      ptr <= next_ptr;
      port_q <= port_d;
    end
  end
  always_comb begin
    read_port_valid_by_bank_by_port = '0;
    read_port_index_by_bank_by_port = '0;
    read_port_rr_by_bank_by_port = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++)
      for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
        read_port_valid_by_bank_by_port[b][p] = port_q[b][p].valid;
        read_port_index_by_bank_by_port[b][p] = port_q[b][p].index;
        read_port_rr_by_bank_by_port[b][p] = port_q[b][p].rr;
      end
  end
endmodule

// File: tb/tb_prf_read_arbiter.sv
// tb_prf_read_arbiter: directed vectors with a queue-based scoreboard for prf_read_arbiter
module tb_prf_read_arbiter;
  logic CLK = 1'b0;
  logic RST;
  logic [13:0] v;
  logic [13:0][6:0] pr;
  logic [13:0] rdy;
  logic [3:0][1:0] pv;
  logic [3:0][1:0][4:0] pidx;
  logic [3:0][1:0][3:0] prr;
  prf_read_arbiter dut (
    .CLK                             (CLK),
    .RST                             (RST),
    .read_req_valid_by_rr            (v),
    .read_req_pr_by_rr               (pr),
    .read_req_ready_by_rr            (rdy),
    .read_port_valid_by_bank_by_port (pv),
    .read_port_index_by_bank_by_port (pidx),
    .read_port_rr_by_bank_by_port    (prr)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  int tests = 0;
  int fails = 0;
  logic [13:0] seen = '0;
  logic [13:0] s_v;
  logic [13:0][6:0] s_pr;
  logic [3:0][1:0] e_v;
  logic [3:0][1:0][4:0] e_idx;
  logic [3:0][1:0][3:0] e_rr;
  int rq_due[$];
  logic [13:0] rq_val[$];
  string rq_nm[$];
  bit rq_acc[$];
  int pq_due[$];
  logic [3:0][1:0] pq_v[$];
  logic [3:0][1:0][4:0] pq_idx[$];
  logic [3:0][1:0][3:0] pq_rr[$];
  string pq_nm[$];
  task automatic clr();
    s_v = '0;
    s_pr = '0;
    e_v = '0;
    e_idx = '0;
    e_rr = '0;
  endtask
  task automatic rq(input int i, input logic [6:0] p);
    s_v[i] = 1'b1;
    s_pr[i] = p;
  endtask
  task automatic ep(input int b, input int p, input logic [4:0] ix, input logic [3:0] r);
    e_v[b][p] = 1'b1;
    e_idx[b][p] = ix;
    e_rr[b][p] = r;
  endtask
  task automatic go(input string nm, input bit r, input logic [13:0] er, input bit acc);
    RST = r;
    v = s_v;
    pr = s_pr;
    rq_due.push_back(cyc);
    rq_val.push_back(er);
    rq_nm.push_back(nm);
    rq_acc.push_back(acc);
    pq_due.push_back(cyc + 1);
    pq_v.push_back(e_v);
    pq_idx.push_back(e_idx);
    pq_rr.push_back(e_rr);
    pq_nm.push_back(nm);
    @(posedge CLK);
    #1;
    clr();
  endtask
  always @(negedge CLK) begin
    logic [13:0] xr;
    string nm;
    logic [3:0][1:0] xv;
    logic [3:0][1:0][4:0] xi, ai;
    logic [3:0][1:0][3:0] xrr, ar;
    while (rq_due.size() > 0 && rq_due[0] == cyc) begin
      void'(rq_due.pop_front());
      xr = rq_val.pop_front();
      nm = rq_nm.pop_front();
      if (rq_acc.pop_front()) seen = seen | rdy;
      tests++;
      if (rdy !== xr) begin
        fails++;
        $display("FAIL %s ready: got %h want %h", nm, rdy, xr);
      end
    end
    while (pq_due.size() > 0 && pq_due[0] == cyc) begin
      void'(pq_due.pop_front());
      xv = pq_v.pop_front();
      xi = pq_idx.pop_front();
      xrr = pq_rr.pop_front();
      nm = pq_nm.pop_front();
      ai = '0;
      ar = '0;
      for (int b = 0; b < 4; b++)
        for (int p = 0; p < 2; p++)
          if (xv[b][p]) begin
            ai[b][p] = pidx[b][p];
            ar[b][p] = prr[b][p];
          end
      tests++;
      if (pv !== xv || ai !== xi || ar !== xrr) begin
        fails++;
        $display("FAIL %s ports: got v=%h idx=%h rr=%h want v=%h idx=%h rr=%h", nm, pv, ai, ar, xv, xi, xrr);
      end
    end
  end
  initial begin
    RST = 1'b1;
    v = '0;
    pr = '0;
    clr();
    @(posedge CLK);
    #1;
    go("reset0", 1, 14'h0000, 0);
    go("reset1", 1, 14'h0000, 0);
    rq(3, 7'h25); ep(1, 0, 5'h09, 4'd3);
    go("single", 0, 14'h0008, 0);
    rq(0, 7'h00); rq(1, 7'h04); rq(2, 7'h08); ep(0, 0, 5'd0, 4'd0); ep(0, 1, 5'd1, 4'd1);
    go("bank0_first", 0, 14'h0003, 0);
    rq(0, 7'h00); rq(1, 7'h04); rq(2, 7'h08); ep(0, 0, 5'd2, 4'd2); ep(0, 1, 5'd0, 4'd0);
    go("bank0_next", 0, 14'h0005, 0);
    rq(2, 7'h09); rq(3, 7'h01); rq(4, 7'h05); ep(1, 0, 5'd1, 4'd4); ep(1, 1, 5'd2, 4'd2);
    go("bank1_ptr4", 0, 14'h0014, 0);
    rq(11, 7'h02); ep(2, 0, 5'd0, 4'd11);
    go("bank2_ptr12", 0, 14'h0800, 0);
    rq(13, 7'h06); rq(1, 7'h0A); ep(2, 0, 5'd1, 4'd13); ep(2, 1, 5'd2, 4'd1);
    go("wrap", 0, 14'h2002, 0);
    for (int i = 0; i < 14; i++) rq(i, 7'(i));
    ep(0, 0, 5'd1, 4'd4); ep(0, 1, 5'd2, 4'd8); ep(1, 0, 5'd1, 4'd5); ep(1, 1, 5'd2, 4'd9);
    ep(2, 0, 5'd0, 4'd2); ep(2, 1, 5'd1, 4'd6); ep(3, 0, 5'd0, 4'd3); ep(3, 1, 5'd1, 4'd7);
    go("all_c0", 0, 14'h03FC, 1);
    for (int i = 0; i < 14; i++) rq(i, 7'(i));
    ep(0, 0, 5'd3, 4'd12); ep(0, 1, 5'd0, 4'd0); ep(1, 0, 5'd3, 4'd13); ep(1, 1, 5'd0, 4'd1);
    ep(2, 0, 5'd2, 4'd10); ep(2, 1, 5'd0, 4'd2); ep(3, 0, 5'd2, 4'd11); ep(3, 1, 5'd0, 4'd3);
    go("all_c1", 0, 14'h3C0F, 1);
    for (int i = 0; i < 14; i++) rq(i, 7'(i));
    ep(0, 0, 5'd1, 4'd4); ep(0, 1, 5'd2, 4'd8); ep(1, 0, 5'd1, 4'd5); ep(1, 1, 5'd2, 4'd9);
    ep(2, 0, 5'd1, 4'd6); ep(2, 1, 5'd2, 4'd10); ep(3, 0, 5'd1, 4'd7); ep(3, 1, 5'd2, 4'd11);
    go("all_c2", 0, 14'h0FF0, 1);
    for (int i = 0; i < 14; i++) rq(i, 7'(i));
    ep(0, 0, 5'd3, 4'd12); ep(0, 1, 5'd0, 4'd0); ep(1, 0, 5'd3, 4'd13); ep(1, 1, 5'd0, 4'd1);
    ep(2, 0, 5'd0, 4'd2); ep(2, 1, 5'd1, 4'd6); ep(3, 0, 5'd0, 4'd3); ep(3, 1, 5'd1, 4'd7);
    go("all_c3", 0, 14'h30CF, 1);
    rq(5, 7'h40); rq(6, 7'h40); ep(0, 0, 5'h10, 4'd5); ep(0, 1, 5'h10, 4'd6);
    go("same_pr", 0, 14'h0060, 0);
    rq(0, 7'h03);
    go("rst_mid", 1, 14'h0001, 0);
    rq(0, 7'h00); rq(13, 7'h04); rq(12, 7'h02); rq(1, 7'h06);
    ep(0, 0, 5'd0, 4'd0); ep(0, 1, 5'd1, 4'd13); ep(2, 0, 5'd1, 4'd1); ep(2, 1, 5'd0, 4'd12);
    go("post_rst_ptr", 0, 14'h3003, 0);
    go("idle", 0, 14'h0000, 0);
    repeat (2) @(posedge CLK);
    #1;
    tests++;
    if (rq_due.size() != 0 || pq_due.size() != 0) begin
      fails++;
      $display("FAIL drain: pending ready=%0d ports=%0d want 0 0", rq_due.size(), pq_due.size());
    end
    tests++;
    if (seen !== 14'h3FFF) begin
      fails++;
      $display("FAIL fairness_union: got %h want 3fff", seen);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
